seg_edit_ctrl: RTL and testbench

Controller for the 4-digit multiplexed 7-segment display on the board. Owns the digit scan schedule, a four-digit BCD value register, and a button-driven edit state machine. Two raw push-buttons step through the digits (`nxt`) and increment the selected digit (`inc`). The selected digit blinks while it is being edited.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 56 +++++
 rtl/seg_edit_ctrl.sv | 131 +++++++++++++
 tb/tb_seg_edit_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment edit controller.
package seg_pkg;

  typedef enum logic [2:0] {IDLE, EDIT0, EDIT1, EDIT2, EDIT3} state_e;

  // Active-low codes, bit order {dp,g,f,e,d,c,b,a}; dp is always off.
  localparam logic [7:0] SEG_CODE [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] SEL_OFF   = 4'b1111;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] code;
    if (d > 4'd9) begin
      code = SEG_BLANK;
    end else begin
      code = SEG_CODE[d];
    end
    return code;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-FF synchronizer, debounce counter, rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE = 250000
) (
  input  logic clk,
  input  logic nRst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

  logic            sync1_q, sync2_q;
  logic [1:0]      vld_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lvl_q, lvl_d, lvl_prev_q;
  logic            armed_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      vld_q      <= 2'b00;
      cnt_q      <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      vld_q      <= {vld_q[0], 1'b1};
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      // Only arm once the synchronized input has genuinely been seen low, so a
      // button held through reset cannot produce a press.
      armed_q    <= armed_q | (vld_q[1] & ~sync2_q);
    end
  end

  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CntMax) begin
        lvl_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press = lvl_q & ~lvl_prev_q & armed_q;

endmodule

// File: rtl/seg_edit_ctrl.sv
// 4-digit multiplexed 7-segment controller with button-driven BCD digit editing and blink.
module seg_edit_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 25000,
  parameter int unsigned DEBOUNCE  = 250000,
  parameter int unsigned BLINK_DIV = 6250000
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        inc,
  input  logic        nxt,
  output logic [7:0]  seg_dat,
  output logic [3:0]  seg_sel,
  output logic [15:0] digits,
  output logic        editing
);

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ScanW-1:0]  ScanMax  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

  logic              inc_p, nxt_p;
  logic [ScanW-1:0]  scan_cnt_q;
  logic [1:0]        slot_q;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              phase_q;
  state_e            state_q, state_d;
  logic [3:0][3:0]   digit_q, digit_d;
  logic [7:0]        seg_dat_q, seg_dat_d;
  logic [3:0]        seg_sel_q, seg_sel_d;
  logic              edit_act;
  logic [1:0]        edit_idx;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_inc_db (
    .clk   (clk),
    .nRst  (nRst),
    .btn   (inc),
    .press (inc_p)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_nxt_db (
    .clk   (clk),
    .nRst  (nRst),
    .btn   (nxt),
    .press (nxt_p)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      scan_cnt_q  <= '0;
      slot_q      <= 2'd0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      state_q     <= IDLE;
      digit_q     <= '0;
      seg_dat_q   <= SEG_BLANK;
      seg_sel_q   <= SEL_OFF;
    end else begin
      if (scan_cnt_q == ScanMax) begin
        scan_cnt_q <= '0;
        slot_q     <= slot_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
      if (blink_cnt_q == BlinkMax) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
      state_q   <= state_d;
      digit_q   <= digit_d;
      seg_dat_q <= seg_dat_d;
      seg_sel_q <= seg_sel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    edit_act = 1'b0;
    edit_idx = 2'd0;
    unique case (state_q)
      IDLE: begin
        if (nxt_p) state_d = EDIT0;
      end
      EDIT0: begin
        edit_act = 1'b1;
        edit_idx = 2'd0;
        if (nxt_p) state_d = EDIT1;
      end
      EDIT1: begin
        edit_act = 1'b1;
        edit_idx = 2'd1;
        if (nxt_p) state_d = EDIT2;
      end
      EDIT2: begin
        edit_act = 1'b1;
        edit_idx = 2'd2;
        if (nxt_p) state_d = EDIT3;
      end
      EDIT3: begin
        edit_act = 1'b1;
        edit_idx = 2'd3;
        if (nxt_p) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // nxt takes priority; a coincident inc is dropped.
    if (edit_act && inc_p && !nxt_p) begin
      digit_d[edit_idx] = (digit_q[edit_idx] >= 4'd9) ? 4'd0 : digit_q[edit_idx] + 4'd1;
    end
  end

  always_comb begin
    seg_sel_d = ~(4'b1000 >> slot_q);
    if (edit_act && phase_q && (slot_q == edit_idx)) begin
      seg_dat_d = SEG_BLANK;
    end else begin
      seg_dat_d = seg_decode(digit_q[slot_q]);
    end
  end

  assign seg_dat = seg_dat_q;
  assign seg_sel = seg_sel_q;
  assign digits  = {digit_q[0], digit_q[1], digit_q[2], digit_q[3]};
  assign editing = (state_q != IDLE);

endmodule

// File: tb/tb_seg_edit_ctrl.sv
// Self-checking bench for seg_edit_ctrl against a behavioural digit/state/scan model.
module tb_seg_edit_ctrl;

  localparam int SCAN   = 4;
  localparam int DEB    = 3;
  localparam int BLINK  = 16;
  localparam int HOLD   = DEB + 6;

  logic        clk = 1'b0;
  logic        nRst;
  logic        inc, nxt;
  logic [7:0]  seg_dat;
  logic [3:0]  seg_sel;
  logic [15:0] digits;
  logic        editing;

  int n_chk = 0;
  int n_err = 0;
  int ncyc  = 0;

  // Model: st = 0 for IDLE, k+1 while editing digit k; dig[0] is leftmost.
  int st;
  int dig [4];
  logic [7:0] codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg_edit_ctrl #(
    .SCAN_DIV  (SCAN),
    .DEBOUNCE  (DEB),
    .BLINK_DIV (BLINK)
  ) dut (
    .clk     (clk),
    .nRst    (nRst),
    .inc     (inc),
    .nxt     (nxt),
    .seg_dat (seg_dat),
    .seg_sel (seg_sel),
    .digits  (digits),
    .editing (editing)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge nRst) begin
    if (!nRst) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_digits();
    return {4'(dig[0]), 4'(dig[1]), 4'(dig[2]), 4'(dig[3])};
  endfunction

  // Outputs after edge n reflect slot/phase as they were after n-1 edges.
  function automatic logic [11:0] exp_seg(input int n);
    int slot, ph;
    logic [3:0] sel;
    logic [7:0] d;
    if (n == 0) return 12'hFFF;
    slot = ((n - 1) / SCAN) % 4;
    ph   = ((n - 1) / BLINK) % 2;
    sel  = 4'b1000 >> slot;
    sel  = ~sel;
    if (st == slot + 1 && ph == 1) d = 8'hFF;
    else                           d = codes[dig[slot]];
    return {sel, d};
  endfunction

  task automatic model_reset();
    st = 0;
    for (int i = 0; i < 4; i++) dig[i] = 0;
  endtask

  task automatic model_apply(input bit i, input bit n);
    if (n) st = (st + 1) % 5;
    else if (i && st != 0) dig[st-1] = (dig[st-1] + 1) % 10;
  endtask

  task automatic press(input bit i, input bit n);
    inc = i;
    nxt = n;
    repeat (HOLD) @(negedge clk);
    inc = 1'b0;
    nxt = 1'b0;
    repeat (HOLD) @(negedge clk);
    model_apply(i, n);
  endtask

  task automatic check_scan(input int k, input string tag);
    for (int c = 0; c < k; c++) begin
      @(negedge clk);
      chk(tag, {20'h0, seg_sel, seg_dat}, {20'h0, exp_seg(ncyc)});
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_digits"}, {16'h0, digits}, {16'h0, exp_digits()});
    chk({tag, "_editing"}, {31'h0, editing}, {31'h0, st != 0});
  endtask

  initial begin
    int op, len;
    nRst = 1'b0;
    inc  = 1'b0;
    nxt  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_seg_dat", {24'h0, seg_dat}, 32'hFF);
    chk("rst_seg_sel", {28'h0, seg_sel}, 32'hF);
    check_regs("rst");

    nRst = 1'b1;
    check_scan(24, "scan_idle");

    press(1'b1, 1'b0);
    check_regs("idle_inc");

    press(1'b0, 1'b1);
    repeat (3) press(1'b1, 1'b0);
    chk("edit0_digits", {16'h0, digits}, 32'h3000);
    check_regs("edit0");
    check_scan(40, "scan_blink0");

    press(1'b0, 1'b1);
    repeat (11) press(1'b1, 1'b0);
    chk("edit1_wrap", {16'h0, digits}, 32'h3100);
    check_regs("edit1");

    inc = 1'b1;
    repeat (2) @(negedge clk);
    inc = 1'b0;
    repeat (HOLD) @(negedge clk);
    check_regs("bounce");

    press(1'b1, 1'b1);
    chk("both_digits", {16'h0, digits}, 32'h3100);
    check_regs("both");
    press(1'b1, 1'b0);
    chk("edit2_inc", {16'h0, digits}, 32'h3110);
    check_scan(8, "scan_edit2");

    for (int it = 0; it < 14; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0, 1: press(1'b1, 1'b0);
        2:    press(1'b0, 1'b1);
        3:    press(1'b1, 1'b1);
        default: begin
          len = $urandom_range(1, DEB - 1);
          if ($urandom_range(0, 1) == 1) inc = 1'b1;
          else                           nxt = 1'b1;
          repeat (len) @(negedge clk);
          inc = 1'b0;
          nxt = 1'b0;
          repeat (HOLD) @(negedge clk);
        end
      endcase
      check_regs("rand");
      check_scan(6, "scan_rand");
    end

    if (st == 0) press(1'b0, 1'b1);
    if (dig[st-1] == 0) press(1'b1, 1'b0);
    check_regs("pre_rst");
    @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_seg_dat", {24'h0, seg_dat}, 32'hFF);
    chk("mid_rst_seg_sel", {28'h0, seg_sel}, 32'hF);
    check_regs("mid_rst");

    nxt = 1'b1;
    @(negedge clk);
    nRst = 1'b1;
    repeat (20) @(negedge clk);
    check_regs("held_nxt");
    nxt = 1'b0;
    repeat (HOLD) @(negedge clk);
    check_regs("released_nxt");
    press(1'b0, 1'b1);
    chk("repress_editing", {31'h0, editing}, 32'h1);
    check_scan(8, "scan_after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
